// File: rtl/serial_frame_rx.sv
// Receive side of the CPLD-to-DSP sample link: oversamples sclk/mosi/frame_n,
// reassembles LSB-first words and presents them with a channel tag on valid/ready.
module serial_frame_rx #(
  parameter int unsigned WORD_BITS       = 12,
  parameter int unsigned WORDS_PER_FRAME = 4,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic                 clkin,
  input  logic                 rst_bar,
  input  logic                 sclk_in,
  input  logic                 mosi_in,
  input  logic                 frame_n_in,
  output logic [WORD_BITS-1:0] rx_data,
  output logic [1:0]           rx_chan,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_done,
  output logic                 err_short,
  output logic                 err_overrun,
  input  logic                 err_clr
);

  localparam int unsigned BIT_CNT_W  = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;
  localparam int unsigned WORD_CNT_W = (WORDS_PER_FRAME > 1) ? $clog2(WORDS_PER_FRAME) : 1;
  localparam int unsigned LAST_BIT   = WORD_BITS - 1;
  localparam int unsigned LAST_WORD  = WORDS_PER_FRAME - 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT    = 2'd1,
    WAIT_END = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic [SYNC_STAGES-1:0] frame_n_sync;
  logic                   sclk_s;
  logic                   mosi_s;
  logic                   frame_n_s;
  logic                   sclk_prev_q;
  logic                   fall_q;
  logic                   mosi_q;

  state_t                 state_q, state_d;
  logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [WORD_CNT_W-1:0]  word_cnt_q, word_cnt_d;
  logic [WORD_BITS-2:0]   shift_q, shift_d;
  logic [WORD_BITS-1:0]   data_d;
  logic [1:0]             chan_d;
  logic                   valid_d;
  logic                   done_d;
  logic                   short_d;
  logic                   ovr_d;

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign frame_n_s = frame_n_sync[SYNC_STAGES-1];

  // Input synchronizers plus a registered falling-edge strobe with its data bit
  always_ff @(posedge clkin or negedge rst_bar) begin
    if (!rst_bar) begin
      sclk_sync    <= '1;
      mosi_sync    <= '0;
      frame_n_sync <= '1;
      sclk_prev_q  <= 1'b1;
      fall_q       <= 1'b0;
      mosi_q       <= 1'b0;
    end else begin
      sclk_sync    <= {sclk_sync[SYNC_STAGES-2:0], sclk_in};
      mosi_sync    <= {mosi_sync[SYNC_STAGES-2:0], mosi_in};
      frame_n_sync <= {frame_n_sync[SYNC_STAGES-2:0], frame_n_in};
      sclk_prev_q  <= sclk_s;
      fall_q       <= sclk_prev_q & ~sclk_s;
      mosi_q       <= mosi_s;
    end
  end

  // State, counters and the registered output buffer
  always_ff @(posedge clkin or negedge rst_bar) begin
    if (!rst_bar) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      word_cnt_q  <= '0;
      shift_q     <= '0;
      rx_data     <= '0;
      rx_chan     <= '0;
      rx_valid    <= 1'b0;
      frame_done  <= 1'b0;
      err_short   <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      word_cnt_q  <= word_cnt_d;
      shift_q     <= shift_d;
      rx_data     <= data_d;
      rx_chan     <= chan_d;
      rx_valid    <= valid_d;
      frame_done  <= done_d;
      err_short   <= short_d;
      err_overrun <= ovr_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    word_cnt_d = word_cnt_q;
    shift_d    = shift_q;
    data_d     = rx_data;
    chan_d     = rx_chan;
    valid_d    = rx_valid;
    done_d     = 1'b0;
    short_d    = err_short;
    ovr_d      = err_overrun;

    if (rx_valid && rx_ready) begin
      valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (!frame_n_s) begin
          state_d    = SHIFT;
          bit_cnt_d  = '0;
          word_cnt_d = '0;
        end
      end

      SHIFT: begin
        if (frame_n_s) begin
          // Frame ended early: a partial word is dropped and flagged
          if (bit_cnt_q != '0) begin
            short_d = 1'b1;
          end
          state_d    = IDLE;
          bit_cnt_d  = '0;
          word_cnt_d = '0;
        end else if (fall_q) begin
          if (bit_cnt_q == BIT_CNT_W'(LAST_BIT)) begin
            data_d  = {mosi_q, shift_q};
            chan_d  = 2'(word_cnt_q);
            valid_d = 1'b1;
            if (rx_valid && !rx_ready) begin
              ovr_d = 1'b1;
            end
            bit_cnt_d = '0;
            if (word_cnt_q == WORD_CNT_W'(LAST_WORD)) begin
              done_d     = 1'b1;
              word_cnt_d = '0;
              state_d    = WAIT_END;
            end else begin
              word_cnt_d = word_cnt_q + WORD_CNT_W'(1);
            end
          end else begin
            shift_d[bit_cnt_q] = mosi_q;
            bit_cnt_d          = bit_cnt_q + BIT_CNT_W'(1);
          end
        end
      end

      WAIT_END: begin
        if (frame_n_s) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    // Clear wins over any error raised in the same cycle
    if (err_clr) begin
      short_d = 1'b0;
      ovr_d   = 1'b0;
    end
  end

endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed bench for serial_frame_rx: table of frames with expected words,
// handshake shape and error flags, plus overrun and mid-frame reset sequences.
module tb_serial_frame_rx;

  localparam int unsigned WB = 12;

  logic          clkin = 1'b0;
  logic          rst_bar;
  logic          sclk_in;
  logic          mosi_in;
  logic          frame_n_in;
  logic [WB-1:0] rx_data;
  logic [1:0]    rx_chan;
  logic          rx_valid;
  logic          rx_ready;
  logic          frame_done;
  logic          err_short;
  logic          err_overrun;
  logic          err_clr;

  always #5 clkin = ~clkin;

  serial_frame_rx #(
    .WORD_BITS      (WB),
    .WORDS_PER_FRAME(4),
    .SYNC_STAGES    (2)
  ) dut (
    .clkin      (clkin),
    .rst_bar    (rst_bar),
    .sclk_in    (sclk_in),
    .mosi_in    (mosi_in),
    .frame_n_in (frame_n_in),
    .rx_data    (rx_data),
    .rx_chan    (rx_chan),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .frame_done (frame_done),
    .err_short  (err_short),
    .err_overrun(err_overrun),
    .err_clr    (err_clr)
  );

  // mode 0: ready held high; 1: ready low until word 1 (overrun); 2: ready only in completion cycles
  typedef struct {
    logic [3:0][WB-1:0] words;
    int                 half;
    int                 mode;
    int                 cut;
    int                 first;
    int                 n_acc;
    int                 n_fd;
    int                 n_rise;
    logic               e_short;
    logic               e_ovr;
  } vec_t;

  typedef struct packed {
    logic [WB-1:0] d;
    logic [1:0]    c;
  } acc_t;

  vec_t vecs[7];
  acc_t acc_q[$];
  int   fd_cnt = 0;
  int   rise_cnt = 0;
  logic [WB-1:0] fd_data = '0;
  logic [1:0]    fd_chan = '0;
  logic          prev_valid = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always @(negedge clkin) begin
    if (rx_valid && rx_ready) acc_q.push_back({rx_data, rx_chan});
    if (frame_done) begin
      fd_cnt++;
      fd_data = rx_data;
      fd_chan = rx_chan;
    end
    if (rx_valid && !prev_valid) rise_cnt++;
    prev_valid = rx_valid;
  end

  function automatic vec_t mk(input logic [WB-1:0] w0, input logic [WB-1:0] w1,
                              input logic [WB-1:0] w2, input logic [WB-1:0] w3,
                              input int half, input int mode, input int cut,
                              input int first, input int n_acc, input int n_fd,
                              input int n_rise, input logic e_short, input logic e_ovr);
    vec_t v;
    v.words[0] = w0;
    v.words[1] = w1;
    v.words[2] = w2;
    v.words[3] = w3;
    v.half     = half;
    v.mode     = mode;
    v.cut      = cut;
    v.first    = first;
    v.n_acc    = n_acc;
    v.n_fd     = n_fd;
    v.n_rise   = n_rise;
    v.e_short  = e_short;
    v.e_ovr    = e_ovr;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clkin);
    #1;
  endtask

  // Drive nbits of w LSB first; mosi moves while sclk is high, receiver samples on the fall
  task automatic send_word(input logic [WB-1:0] w, input int nbits, input int half,
                           input bit pulse_rdy);
    for (int b = 0; b < nbits; b++) begin
      mosi_in = w[b];
      wait_cyc(half);
      sclk_in = 1'b0;
      if (pulse_rdy && b == WB - 1) begin
        fork
          begin
            wait_cyc(3);
            rx_ready = 1'b1;
            wait_cyc(1);
            rx_ready = 1'b0;
          end
        join_none
      end
      wait_cyc(half);
      sclk_in = 1'b1;
    end
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    int   base_acc;
    int   base_fd;
    int   base_rise;
    int   n;
    int   left;
    acc_t a;
    v         = vecs[i];
    base_acc  = acc_q.size();
    base_fd   = fd_cnt;
    base_rise = rise_cnt;
    rx_ready  = (v.mode == 0);
    frame_n_in = 1'b0;
    wait_cyc(4);
    for (int k = 0; k < 4; k++) begin
      left = v.cut - k * WB;
      if (left > 0) begin
        send_word(v.words[k], (left >= WB) ? WB : left, v.half, (v.mode == 2) && (k >= 1));
      end
      if (v.mode == 1 && k == 1) begin
        wait_cyc(6);
        check($sformatf("v%0d ovr_set", i), err_overrun, 1);
        check($sformatf("v%0d ovr_data", i), rx_data, v.words[1]);
        check($sformatf("v%0d ovr_chan", i), rx_chan, 1);
        err_clr = 1'b1;
        wait_cyc(1);
        err_clr = 1'b0;
        check($sformatf("v%0d ovr_clr", i), err_overrun, 0);
        rx_ready = 1'b1;
      end
    end
    wait_cyc(6);
    rx_ready = 1'b1;
    wait_cyc(2);
    frame_n_in = 1'b1;
    wait_cyc(6);

    n = acc_q.size() - base_acc;
    check($sformatf("v%0d n_acc", i), n, v.n_acc);
    for (int j = 0; j < n && j < v.n_acc; j++) begin
      a = acc_q[base_acc + j];
      check($sformatf("v%0d w%0d data", i, j), a.d, v.words[v.first + j]);
      check($sformatf("v%0d w%0d chan", i, j), a.c, v.first + j);
    end
    check($sformatf("v%0d n_frame_done", i), fd_cnt - base_fd, v.n_fd);
    if (v.n_fd > 0) begin
      check($sformatf("v%0d fd_data", i), fd_data, v.words[3]);
      check($sformatf("v%0d fd_chan", i), fd_chan, 3);
    end
    check($sformatf("v%0d n_valid_rise", i), rise_cnt - base_rise, v.n_rise);
    check($sformatf("v%0d err_short", i), err_short, v.e_short);
    check($sformatf("v%0d err_overrun", i), err_overrun, v.e_ovr);
    err_clr = 1'b1;
    wait_cyc(1);
    err_clr = 1'b0;
    check($sformatf("v%0d errs_cleared", i), {err_short, err_overrun}, 0);
  endtask

  initial begin
    rst_bar    = 1'b0;
    sclk_in    = 1'b1;
    mosi_in    = 1'b0;
    frame_n_in = 1'b1;
    rx_ready   = 1'b1;
    err_clr    = 1'b0;

    //            w0      w1      w2      w3    half mode cut first acc fd rise short ovr
    vecs[0] = mk(12'h123, 12'h456, 12'h789, 12'hABC, 2, 0, 48, 0, 4, 1, 4, 1'b0, 1'b0);
    vecs[1] = mk(12'h123, 12'h456, 12'h789, 12'hABC, 2, 1, 48, 1, 3, 1, 3, 1'b0, 1'b0);
    vecs[2] = mk(12'h123, 12'h456, 12'h789, 12'hABC, 2, 2, 48, 0, 4, 1, 1, 1'b0, 1'b0);
    vecs[3] = mk(12'h123, 12'h456, 12'h789, 12'hABC, 2, 0, 31, 0, 2, 0, 2, 1'b1, 1'b0);
    vecs[4] = mk(12'h5A5, 12'h0F0, 12'h3C3, 12'hFFE, 2, 0, 48, 0, 4, 1, 4, 1'b0, 1'b0);
    vecs[5] = mk(12'hFFF, 12'h000, 12'h800, 12'h001, 2, 0, 48, 0, 4, 1, 4, 1'b0, 1'b0);
    vecs[6] = mk(12'hAAA, 12'h555, 12'hAAA, 12'h555, 1, 0, 48, 0, 4, 1, 4, 1'b0, 1'b0);

    wait_cyc(3);
    rst_bar = 1'b1;
    wait_cyc(2);
    check("reset_outputs", {rx_data, rx_chan, rx_valid, frame_done, err_short, err_overrun}, 0);

    for (int i = 0; i < 5; i++) run_vec(i);

    // Asynchronous reset in the middle of a word with a word still held in the buffer
    rx_ready   = 1'b0;
    frame_n_in = 1'b0;
    wait_cyc(4);
    send_word(12'h3C5, WB, 2, 1'b0);
    send_word(12'h0F0, 5, 2, 1'b0);
    wait_cyc(5);
    check("pre_rst_valid", rx_valid, 1);
    check("pre_rst_data", rx_data, 12'h3C5);
    @(negedge clkin);
    #2 rst_bar = 1'b0;
    #1 check("async_rst_outputs", {rx_data, rx_chan, rx_valid, frame_done, err_short, err_overrun}, 0);
    frame_n_in = 1'b1;
    sclk_in    = 1'b1;
    mosi_in    = 1'b0;
    rx_ready   = 1'b1;
    wait_cyc(3);
    rst_bar = 1'b1;
    wait_cyc(4);

    for (int i = 5; i < 7; i++) run_vec(i);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
